// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stall/flush/halt controller:
// FSM state encoding, ECALL halt code and drain defaults.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // a7 (x17) value that marks an ECALL as end-of-program
    localparam logic [31:0] ECALL_HALT_CODE = 32'd10;

    localparam int DRAIN_CYCLES_DEFAULT = 2;
    localparam int DRAIN_CNT_W          = 3;

    // Drain count loaded on halt acceptance; out-of-range values clamp into 1..7
    function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int cycles);
        logic [DRAIN_CNT_W-1:0] val;
        if (cycles < 1) begin
            val = 3'd1;
        end else if (cycles > 7) begin
            val = 3'd7;
        end else begin
            val = 3'(cycles);
        end
        return val;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running performance counter with enable; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, natural wrap on overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush/halt responder for the 5-stage core: decodes per-stage
// register enables, sequences the end-of-program drain, counts stalls/flushes.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_detected,
    input  logic             branch_mispredict,
    input  logic             mem_busy,
    input  logic             halt_ex,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = drain_load(DRAIN_CYCLES);

    state_t                 state_r;
    state_t                 state_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt_r;
    logic [DRAIN_CNT_W-1:0] drain_cnt_next;
    logic                   halted_r;
    logic                   stall_en;
    logic                   flush_en;

    // State, drain counter and halted flag; halted rises on the same edge the FSM enters HALTED
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RUN;
            drain_cnt_r <= 3'd0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next;
            drain_cnt_r <= drain_cnt_next;
            halted_r    <= (state_next == HALTED);
        end
    end

    assign halted = halted_r;

    // Next-state and zero-latency enable decode; enables must gate the same edge
    always_comb begin
        state_next     = state_r;
        drain_cnt_next = drain_cnt_r;
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_write    = 1'b0;
        id_ex_bubble   = 1'b0;
        ex_mem_write   = 1'b0;
        mem_wb_write   = 1'b0;
        stall_en       = 1'b0;
        flush_en       = 1'b0;

        case (state_r)
            RUN: begin
                if (mem_busy) begin
                    // full freeze; every other request waits for the memory
                    stall_en = 1'b1;
                end else if (branch_mispredict) begin
                    // squash the wrong-path instructions, including any stalled one
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_write  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                    flush_en     = 1'b1;
                end else if (hazard_detected) begin
                    id_ex_write  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                    stall_en     = 1'b1;
                end else begin
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    id_ex_write  = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                end

                if (halt_ex && !mem_busy) begin
                    state_next     = DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end else begin
                    state_next     = RUN;
                    drain_cnt_next = drain_cnt_r;
                end
            end

            DRAIN: begin
                // front end held, bubbles fed behind the halting instruction
                id_ex_write  = !mem_busy;
                id_ex_bubble = 1'b1;
                ex_mem_write = !mem_busy;
                mem_wb_write = !mem_busy;
                stall_en     = mem_busy;

                if (!mem_busy) begin
                    drain_cnt_next = drain_cnt_r - 3'd1;
                    if (drain_cnt_r == 3'd1) begin
                        state_next = HALTED;
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    drain_cnt_next = drain_cnt_r;
                    state_next     = DRAIN;
                end
            end

            HALTED: begin
                state_next     = HALTED;
                drain_cnt_next = drain_cnt_r;
            end

            default: begin
                state_next     = RUN;
                drain_cnt_next = 3'd0;
            end
        endcase
    end

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .count (stall_cycles)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .en    (flush_en),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed scenarios plus random traffic.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 32;
    localparam int DC    = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             hazard_detected = 1'b0;
    logic             branch_mispredict = 1'b0;
    logic             mem_busy = 1'b0;
    logic             halt_ex = 1'b0;
    logic             pc_write, if_id_write, if_id_flush, id_ex_write;
    logic             id_ex_bubble, ex_mem_write, mem_wb_write, halted;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [6:0]       en_vec;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0]  en;
        logic        halted;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb[$];

    int          m_state = 0;
    int          m_cnt   = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    pipeline_stall_ctrl #(
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .hazard_detected   (hazard_detected),
        .branch_mispredict (branch_mispredict),
        .mem_busy          (mem_busy),
        .halt_ex           (halt_ex),
        .pc_write          (pc_write),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_write       (id_ex_write),
        .id_ex_bubble      (id_ex_bubble),
        .ex_mem_write      (ex_mem_write),
        .mem_wb_write      (mem_wb_write),
        .halted            (halted),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    assign en_vec = {pc_write, if_id_write, if_id_flush, id_ex_write,
                     id_ex_bubble, ex_mem_write, mem_wb_write};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge
    task automatic do_reset();
        #2;
        hazard_detected   = 1'b0;
        branch_mispredict = 1'b0;
        mem_busy          = 1'b0;
        halt_ex           = 1'b0;
        reset             = 1'b1;
        #1;
        m_state = 0;
        m_cnt   = 0;
        m_stall = 32'd0;
        m_flush = 32'd0;
        sb.delete();
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_stall", {32'd0, stall_cycles}, 64'd0);
        check("rst_flush", {32'd0, flush_count}, 64'd0);
        check("rst_enables", {57'd0, en_vec}, {57'd0, 7'b1101011});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, push model expectations, then compare enables and registered state
    task automatic cycle(input logic hz, input logic bm, input logic mb, input logic hx);
        exp_t e;
        exp_t got_e;
        hazard_detected   = hz;
        branch_mispredict = bm;
        mem_busy          = mb;
        halt_ex           = hx;
        e = '0;
        case (m_state)
            0: begin
                if (mb)      e.en = 7'b0000000;
                else if (bm) e.en = 7'b1111111;
                else if (hz) e.en = 7'b0001111;
                else         e.en = 7'b1101011;
                if (mb || (hz && !bm)) m_stall = m_stall + 32'd1;
                if (bm && !mb) m_flush = m_flush + 32'd1;
                if (hx && !mb) begin
                    m_state = 1;
                    m_cnt   = DC;
                end
            end
            1: begin
                e.en = {3'b000, !mb, 1'b1, !mb, !mb};
                if (mb) begin
                    m_stall = m_stall + 32'd1;
                end else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_state = 2;
                end
            end
            default: e.en = 7'b0000000;
        endcase
        e.halted = (m_state == 2);
        e.stall  = m_stall;
        e.flush  = m_flush;
        sb.push_back(e);

        @(negedge clk);
        check("enables", {57'd0, en_vec}, {57'd0, sb[0].en});
        @(posedge clk);
        #1;
        got_e = sb.pop_front();
        check("halted", {63'd0, halted}, {63'd0, got_e.halted});
        check("stall_cycles", {32'd0, stall_cycles}, {32'd0, got_e.stall});
        check("flush_count", {32'd0, flush_count}, {32'd0, got_e.flush});
    endtask

    initial begin
        // load-use hazard
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("ld_use_stall", {32'd0, stall_cycles}, 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // mispredict overrides hazard
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("bm_hz_flush", {32'd0, flush_count}, 64'd1);
        check("bm_hz_stall", {32'd0, stall_cycles}, 64'd0);

        // memory busy freezes a pending mispredict
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("busy_flush_held", {32'd0, flush_count}, 64'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("busy_flush", {32'd0, flush_count}, 64'd1);
        check("busy_stall", {32'd0, stall_cycles}, 64'd3);

        // halt with no busy: halted on the 3rd edge, then inputs ignored
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_not_yet", {63'd0, halted}, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_rise", {63'd0, halted}, 64'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("halted_stall_frozen", {32'd0, stall_cycles}, 64'd0);

        // halt with busy during drain
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("drain_busy_not_yet", {63'd0, halted}, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("drain_busy_halt", {63'd0, halted}, 64'd1);
        check("drain_busy_stall", {32'd0, stall_cycles}, 64'd2);

        // async reset out of HALTED, then random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic bm;
            logic hx;
            bm = ($urandom_range(0, 3) == 0);
            hx = !bm && ($urandom_range(0, 39) == 0);
            cycle(1'($urandom_range(0, 1)), bm, ($urandom_range(0, 3) == 0), hx);
            if (halted && ($urandom_range(0, 7) == 0)) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central pipeline-control responder for the 5-stage RISC-V core. It consumes stall, flush and halt requests from the hazard-detection unit, the EX-stage branch resolver, the data-memory port and the ECALL decoder. It converts them into per-stage pipeline-register write enables and bubble/flush strobes. It sequences the end-of-program drain and keeps performance counters for stall and flush cycles.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter
- DRAIN_CYCLES, 2, cycles needed after halt acceptance to retire the halting instruction through MEM and WB (legal range 1..7)

Ports:
- clk  input  1  core clock; one clock domain; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- hazard_detected  input  1  load-use hazard on the instruction in ID
- branch_mispredict  input  1  EX-stage resolved control flow differs from the prediction; the PC mux redirects in the same cycle
- mem_busy  input  1  data memory cannot complete the access in MEM this cycle
- halt_ex  input  1  ECALL with x17 == 10 is valid in EX
- pc_write  output  1  PC register load enable
- if_id_write  output  1  IF/ID register load enable
- if_id_flush  output  1  IF/ID loads a NOP (valid cleared)
- id_ex_write  output  1  ID/EX register load enable
- id_ex_bubble  output  1  ID/EX loads a bubble (control bits zeroed)
- ex_mem_write  output  1  EX/MEM load enable
- mem_wb_write  output  1  MEM/WB load enable
- halted  output  1  pipeline fully drained; level, held until reset
- stall_cycles  output  CNT_W  count of cycles with load-use or memory stall
- flush_count  output  CNT_W  count of accepted mispredict flushes

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state: RUN. Drain counter is 3 bits and resets to 0.
- Output priority in RUN, highest first:
  - mem_busy: all five write enables 0, no flush or bubble; the pipeline freezes and other requests are ignored this cycle.
  - branch_mispredict: all write enables 1, if_id_flush=1, id_ex_bubble=1. This overrides hazard_detected because the stalled instruction is squashed.
  - hazard_detected: pc_write=0, if_id_write=0, id_ex_bubble=1, downstream write enables 1.
  - Otherwise: all write enables 1, flush and bubble 0.
- Halt acceptance:
  - Condition: RUN and halt_ex and not mem_busy.
  - Next state is DRAIN, with the counter loaded to DRAIN_CYCLES.
  - The acceptance cycle applies the normal RUN outputs. halt_ex and branch_mispredict are never both asserted.
- DRAIN:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1; ex_mem_write and mem_wb_write follow !mem_busy.
  - The counter decrements only when mem_busy=0. The FSM moves to HALTED when a decrement takes the counter from 1 to 0.
  - hazard_detected, branch_mispredict and halt_ex are ignored.
- HALTED: all write enables 0, flush and bubble 0, halted=1. The FSM stays here until reset.
- Counters:
  - stall_cycles increments in RUN when mem_busy or hazard_detected is asserted, and in DRAIN when mem_busy is asserted.
  - flush_count increments when a mispredict is accepted, i.e. in RUN with mem_busy=0.
  - Both counters wrap modulo 2^CNT_W and are frozen in HALTED.

## Timing
- All enable, flush and bubble outputs are combinational from the current state and inputs, with zero latency, because they must gate the same edge.
- halted, the FSM state, the drain counter and the performance counters are registered.
- Reset values: state RUN; halted=0; stall_cycles=0; flush_count=0. Combinational outputs at reset with all inputs low: every write enable 1, if_id_flush=0, id_ex_bubble=0.
- A reset asserted mid-DRAIN or in HALTED returns the block to RUN immediately, without waiting for a clock edge.
- Halt latency: halted rises exactly DRAIN_CYCLES non-busy cycles after the acceptance edge.

## Structure
- Shared package (pipeline_pkg) holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2)
  - the ECALL halt code constant 10
  - the default DRAIN_CYCLES
- One natural sub-module: perf_counter (CNT_W wide, with enable, asynchronous reset and wrap), instantiated twice.
- FSM, drain counter and output decode stay in the top module.

## Test plan
- Load-use hazard: hazard_detected=1 for one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1; stall_cycles goes 0 to 1.
- Simultaneous hazard_detected=1 and branch_mispredict=1 -> pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_count=1, stall_cycles=0.
- mem_busy=1 for 3 cycles together with branch_mispredict=1 -> all enables 0 for 3 cycles and flush_count stays 0. Mispredict accepted in cycle 4 -> flush_count=1; stall_cycles=3.
- halt_ex pulse, DRAIN_CYCLES=2, no busy -> halted rises on the 3rd edge after the acceptance cycle; all enables 0 afterwards; later hazard or mispredict inputs produce no change.
- halt_ex accepted, then mem_busy=1 for 2 cycles during DRAIN -> ex_mem_write=0 on those cycles; halted is delayed by 2 cycles; stall_cycles increases by 2.
- Reset asserted asynchronously in HALTED between clock edges -> halted=0, both counters 0 and pc_write=1 before the next clock edge.
